// File: rtl/csync_scheduler.sv
// csync_scheduler: line-locked composite sync from separate hsync/vsync.
// Define CSYNC_EQ_EN to add post-vsync equalizing lines (EQ mode).
module csync_scheduler #(
  parameter int CNT_WIDTH = 8,
  parameter int EQ_LINES  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hsync,
  input  logic                 vsync,
  output logic                 csync,
  output logic                 locked,
  output logic [1:0]           mode,
  output logic [CNT_WIDTH-1:0] line_len
);

  typedef enum logic [1:0] {
    M_NORMAL = 2'd0,
    M_VSERR  = 2'd1,
    M_EQ     = 2'd2
  } mode_e;

  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic                 hs_q, hs_p_q, vs_q, vs_p_q;
  logic                 hfall, hrise, vfall, vrise;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d, meas;
  logic                 lock_q, lock_d, sat;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] hsw_q, hsw_d;
  logic [CNT_WIDTH-1:0] half, h_last;
  logic [CNT_WIDTH-1:0] ph_q, ph_d, thr;
  mode_e                mode_q, mode_d;
  logic                 pf_q, pf_d, pr_q, pr_d;
  logic                 fall_e, rise_e;
  logic                 cs_q, cs_d;
`ifdef CSYNC_EQ_EN
  localparam logic [CNT_WIDTH-1:0] EQ_LAST =
    CNT_WIDTH'(EQ_LINES - 1);
  logic [CNT_WIDTH-1:0] eq_q, eq_d, eqw;
`endif

  assign hfall  = hs_p_q & ~hs_q;
  assign hrise  = ~hs_p_q & hs_q;
  assign vfall  = vs_p_q & ~vs_q;
  assign vrise  = ~vs_p_q & vs_q;
  assign fall_e = pf_q | vfall;
  assign rise_e = pr_q | vrise;

  assign sat    = (cnt_q == CMAX);
  assign meas   = sat ? CMAX : cnt_q + ONE;
  assign half   = len_q >> 1;
  assign h_last = (half == '0) ? '0 : half - ONE;
  assign thr    = (hsw_q >= half) ? '0 : half - hsw_q;
`ifdef CSYNC_EQ_EN
  assign eqw    = ((hsw_q >> 1) == '0) ? ONE : (hsw_q >> 1);
`endif

  // input sync stage plus one-deep history for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q   <= 1'b1;
      hs_p_q <= 1'b1;
      vs_q   <= 1'b1;
      vs_p_q <= 1'b1;
    end else begin
      hs_q   <= hsync;
      hs_p_q <= hs_q;
      vs_q   <= vsync;
      vs_p_q <= vs_q;
    end
  end

  // line period, hsync width, lock and half-line phase next state
  always_comb begin
    cnt_d  = hfall ? '0 : (sat ? cnt_q : cnt_q + ONE);
    len_d  = hfall ? meas : len_q;
    lock_d = lock_q;
    if (sat) begin
      lock_d = 1'b0;
    end else if (hfall) begin
      lock_d = (meas == len_q);
    end
    if (hs_q) begin
      wcnt_d = '0;
    end else begin
      wcnt_d = (wcnt_q == CMAX) ? wcnt_q : wcnt_q + ONE;
    end
    hsw_d = hrise ? wcnt_q : hsw_q;
    ph_d  = (hfall || ph_q >= h_last) ? '0 : ph_q + ONE;
  end

  // measurement registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      len_q  <= '0;
      lock_q <= 1'b0;
      wcnt_q <= '0;
      hsw_q  <= '0;
      ph_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      lock_q <= lock_d;
      wcnt_q <= wcnt_d;
      hsw_q  <= hsw_d;
      ph_q   <= ph_d;
    end
  end

  // mode FSM: vsync edges wait as pending flags until the next hfall
  always_comb begin
    mode_d = mode_q;
    pf_d   = fall_e;
    pr_d   = rise_e;
`ifdef CSYNC_EQ_EN
    eq_d   = eq_q;
`endif
    if (!lock_q) begin
      mode_d = M_NORMAL;
      pf_d   = 1'b0;
      pr_d   = 1'b0;
`ifdef CSYNC_EQ_EN
      eq_d   = '0;
`endif
    end else if (hfall) begin
      pf_d = 1'b0;
      pr_d = 1'b0;
      unique case (mode_q)
        M_NORMAL: begin
          if (fall_e) begin
            mode_d = M_VSERR;
            pr_d   = rise_e;
          end
        end
        M_VSERR: begin
          if (rise_e) begin
`ifdef CSYNC_EQ_EN
            mode_d = M_EQ;
            eq_d   = '0;
`else
            mode_d = M_NORMAL;
`endif
          end
        end
`ifdef CSYNC_EQ_EN
        M_EQ: begin
          if (fall_e) begin
            mode_d = M_VSERR;
          end else if (eq_q == EQ_LAST) begin
            mode_d = M_NORMAL;
          end else begin
            eq_d = eq_q + ONE;
          end
        end
`endif
        default: mode_d = M_NORMAL;
      endcase
    end
  end

  // csync pattern selected by lock and mode
  always_comb begin
    cs_d = hs_q & vs_q;
    if (lock_q) begin
      unique case (mode_q)
        M_NORMAL: cs_d = hs_q;
        M_VSERR: begin
          if (hsw_q >= half) cs_d = 1'b0;
          else cs_d = (ph_q >= thr);
        end
`ifdef CSYNC_EQ_EN
        M_EQ: cs_d = (ph_q >= eqw);
`endif
        default: cs_d = hs_q;
      endcase
    end
  end

  // mode, pending flags and csync output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_NORMAL;
      pf_q   <= 1'b0;
      pr_q   <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      mode_q <= mode_d;
      pf_q   <= pf_d;
      pr_q   <= pr_d;
      cs_q   <= cs_d;
    end
  end

`ifdef CSYNC_EQ_EN
  // equalizing line counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eq_q <= '0;
    else eq_q <= eq_d;
  end
`endif

  assign csync    = cs_q;
  assign locked   = lock_q;
  assign mode     = mode_q;
  assign line_len = len_q;

endmodule
